// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and constants for the sequenced multiword CLA adder
// Purpose: FSM state encoding, slice width and index-width helper used by
//          cla_multiword_seq and cla4_slice.
package cla_seq_pkg;

    localparam int CHUNK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit so a
    // single-nibble build still has a legal counter.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead slice
// Purpose: one nibble of carry-lookahead addition, no storage.
// Ports:
//   a[3:0], b[3:0]  nibble operands
//   c0              carry into bit 0
//   s[3:0]          nibble sum
//   c3              carry into bit 3 (needed for signed overflow on the top nibble)
//   c4              carry out of bit 3
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic       w_c1;
    logic       w_c2;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is expanded directly from generate/propagate terms so no
    // carry waits on the previous one.
    assign w_c1 = w_g[0] | (w_p[0] & c0);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
    assign c3   = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c0);
    assign c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);

    assign s = w_p ^ {c3, w_c2, w_c1, c0};

endmodule

// File: rtl/cla_multiword_seq.sv
// rtl/cla_multiword_seq.sv - WIDTH-bit add/subtract using one shared 4-bit CLA slice, one nibble per cycle
// Purpose: accepts an operand pair over a valid/ready handshake, runs NCHUNK
//          passes through a single cla4_slice, and presents the result over a
//          second valid/ready handshake.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     request handshake; in_a, in_b, in_cin, in_sub operands
//   abort                 cancels an operation in progress (RUN only)
//   out_valid/out_ready   result handshake; out_sum, out_cout, out_ovf result
//   busy                  FSM not idle
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((WIDTH < CHUNK_W) || ((WIDTH % CHUNK_W) != 0)) begin : g_bad_width
            $error("cla_multiword_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_ovf;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [CHUNK_W-1:0] w_a_nib;
    logic [CHUNK_W-1:0] w_b_nib;
    logic [CHUNK_W-1:0] w_s_nib;
    logic               w_c3;
    logic               w_c4;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_a_nib = r_a[CHUNK_W*int'(r_idx) +: CHUNK_W];
    assign w_b_nib = r_b[CHUNK_W*int'(r_idx) +: CHUNK_W];

    cla4_slice u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .c0 (r_carry),
        .s  (w_s_nib),
        .c3 (w_c3),
        .c4 (w_c4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort only matters in RUN; a finished result in DONE is never dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        // Back-to-back: hand off and start the next op with no idle cycle.
                        w_accept    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is A + ~B + 1, so B is inverted once here and the
            // slice only ever adds.
            r_a     <= in_a;
            r_b     <= in_b ^ {WIDTH{in_sub}};
            r_carry <= in_sub | in_cin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum[CHUNK_W*int'(r_idx) +: CHUNK_W] <= w_s_nib;
            r_carry <= w_c4;
            if (w_last) begin
                r_ovf <= w_c3 ^ w_c4;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
    assign out_ovf   = r_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cla_multiword_seq.sv
// tb/tb_cla_multiword_seq.sv - directed self-checking bench for cla_multiword_seq
module tb_cla_multiword_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;

    logic        n_in_valid;
    logic        n_in_ready;
    logic [3:0]  n_in_a;
    logic [3:0]  n_in_b;
    logic        n_out_valid;
    logic [3:0]  n_out_sum;
    logic        n_out_cout;
    logic        n_out_ovf;
    logic        n_busy;

    int n_pass;
    int n_total;
    int lat;

    cla_multiword_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    cla_multiword_seq #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_a      (n_in_a),
        .in_b      (n_in_b),
        .in_cin    (1'b0),
        .in_sub    (1'b0),
        .abort     (1'b0),
        .out_valid (n_out_valid),
        .out_ready (1'b1),
        .out_sum   (n_out_sum),
        .out_cout  (n_out_cout),
        .out_ovf   (n_out_ovf),
        .busy      (n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one request from IDLE, measure latency, check the result, retire it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sum"}, out_sum, exp_sum);
        check({tag, " cout"}, out_cout, exp_cout);
        check({tag, " ovf"}, out_ovf, exp_ovf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " idle after handshake"}, busy, 1'b0);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        abort = 1'b0; out_ready = 1'b0; n_in_valid = 1'b0; n_in_a = '0; n_in_b = '0;
        step();
        step();
        check("reset in_ready low", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset sum", out_sum, 16'h0000);
        check("reset cout", out_cout, 1'b0);
        check("reset ovf", out_ovf, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 1'b1);

        run_op("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add 7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add cin 00FF+0000+1", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("sub 0005-0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub 8000-0001", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Stall in DONE, then back-to-back accept.
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("stall out_valid", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall out_valid held", out_valid, 1'b1);
            check("stall sum held", out_sum, 16'h3333);
            check("stall in_ready low", in_ready, 1'b0);
        end
        in_a = 16'h0001; in_b = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b no bubble busy", busy, 1'b1);
        check("b2b out_valid dropped", out_valid, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("b2b latency", lat, 4);
        check("b2b sum", out_sum, 16'h0002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Abort while idx=2.
        in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort in_ready", in_ready, 1'b1);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) lat++;
        end
        check("abort out_valid never", lat, 0);
        run_op("after abort 3+4", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Reset in the middle of an operation.
        in_a = 16'h7FFF; in_b = 16'h7FFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready low", in_ready, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        check("mid reset out_valid", out_valid, 1'b0);
        check("mid reset busy", busy, 1'b0);
        check("mid reset sum", out_sum, 16'h0000);
        check("mid reset cout", out_cout, 1'b0);
        check("mid reset ovf", out_ovf, 1'b0);
        check("mid reset in_ready", in_ready, 1'b1);

        // Single-nibble build.
        n_in_a = 4'hF; n_in_b = 4'h1; n_in_valid = 1'b1;
        #1;
        check("w4 in_ready", n_in_ready, 1'b1);
        step();
        n_in_valid = 1'b0;
        lat = 0;
        while (!n_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("w4 latency", lat, 1);
        check("w4 sum", n_out_sum, 4'h0);
        check("w4 cout", n_out_cout, 1'b1);
        check("w4 ovf", n_out_ovf, 1'b0);
        step();
        check("w4 idle", n_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
